dma_tile_sched: RTL

Read-side scheduler for the DMA input-tile fetch. On a start pulse it walks one input tile, TIF feature maps of TIY rows each, in map-major order. For every row it issues one burst request of TIX words to the DMA read engine and waits for that burst to finish before issuing the next. It sits between the layer controller, which supplies base address and strides, and the DMA read channel.

---
 rtl/dma_tile_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/dma_tile_sched.sv
// Read-side DMA tile fetch scheduler: walks TIF maps x TIY rows of one input tile,
// issuing one TIX-word burst per row and waiting for each burst to finish.
module dma_tile_sched #(
    parameter int unsigned TIX      = 14,
    parameter int unsigned TIY      = 14,
    parameter int unsigned TIF      = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned STRIDE_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [STRIDE_W-1:0]      row_stride,
    input  logic [STRIDE_W-1:0]      map_stride,
    output logic                     req_valid,
    output logic [ADDR_W-1:0]        req_addr,
    output logic [$clog2(TIX+1)-1:0] req_len,
    input  logic                     req_ready,
    input  logic                     burst_done,
    output logic [$clog2(TIY)-1:0]   cur_row,
    output logic [$clog2(TIF)-1:0]   cur_map,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned LenW = $clog2(TIX + 1);
    localparam int unsigned RowW = $clog2(TIY);
    localparam int unsigned MapW = $clog2(TIF);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state;
    logic [ADDR_W-1:0] row_ptr;
    logic [ADDR_W-1:0] map_ptr;
    logic [ADDR_W-1:0] row_stride_q;
    logic [ADDR_W-1:0] map_stride_q;

    assign req_addr = row_ptr;
    assign req_len  = LenW'(TIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            row_ptr      <= '0;
            map_ptr      <= '0;
            row_stride_q <= '0;
            map_stride_q <= '0;
            cur_row      <= '0;
            cur_map      <= '0;
            req_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        // Strides are zero-extended (or truncated) to the address width.
                        row_stride_q <= ADDR_W'(row_stride);
                        map_stride_q <= ADDR_W'(map_stride);
                        row_ptr      <= base_addr;
                        map_ptr      <= base_addr;
                        cur_row      <= '0;
                        cur_map      <= '0;
                        req_valid    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= StIssue;
                    end
                end
                StIssue: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (burst_done) begin
                        if (cur_row != RowW'(TIY - 1)) begin
                            cur_row   <= cur_row + 1'b1;
                            row_ptr   <= row_ptr + row_stride_q;
                            req_valid <= 1'b1;
                            state     <= StIssue;
                        end else if (cur_map != MapW'(TIF - 1)) begin
                            // Next map starts at the advanced map pointer.
                            cur_row   <= '0;
                            cur_map   <= cur_map + 1'b1;
                            map_ptr   <= map_ptr + map_stride_q;
                            row_ptr   <= map_ptr + map_stride_q;
                            req_valid <= 1'b1;
                            state     <= StIssue;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
